// File: rtl/pipeline_controller_pkg.sv
// Shared types for the pipeline control slice: controller state encoding.
package cpu_types;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    DRAIN   = 2'd1,
    HALTED  = 2'd2,
    RESTART = 2'd3
  } pipe_ctrl_state_t;

endpackage

// File: rtl/perf_counters.sv
// Free-running performance counters (cycles, stalls, flushes), wrapping modulo 2^CNT_WIDTH.
module perf_counters #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cycle_inc,
  input  logic                 stall_inc,
  input  logic                 flush_inc,
  output logic [CNT_WIDTH-1:0] cycle_cnt,
  output logic [CNT_WIDTH-1:0] stall_cnt,
  output logic [CNT_WIDTH-1:0] flush_cnt
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_cnt <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (cycle_inc) cycle_cnt <= cycle_cnt + CNT_WIDTH'(1);
      if (stall_inc) stall_cnt <= stall_cnt + CNT_WIDTH'(1);
      if (flush_inc) flush_cnt <= flush_cnt + CNT_WIDTH'(1);
    end
  end

endmodule

// File: rtl/pipeline_controller.sv
// Five-stage pipeline stall/flush/halt controller with EBREAK drain and debug restart.
// Optional perf counters are built when PIPELINE_PERF_COUNTERS_EN is defined.
//
// state   | meaning
// RUN     | normal issue; handles mem freeze, operand stall, jump flush
// DRAIN   | EBREAK in flight; bubbles into ID/EX until it retires
// HALTED  | pipeline frozen waiting for resume
// RESTART | one cycle refetch with flush, then back to RUN
module pipeline_controller
  import cpu_types::*;
#(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 decode_valid,
  input  logic                 decode_ready,
  input  logic                 jump,
  input  logic                 ebreak_decoded,
  input  logic                 ebreak_retired,
  input  logic                 mem_busy,
  input  logic                 resume,
  output logic                 fetch_en,
  output logic                 fetch_flush,
  output logic                 if_id_en,
  output logic                 id_ex_en,
  output logic                 ex_mem_en,
  output logic                 mem_wb_en,
  output logic                 id_ex_bubble,
  output logic                 halted,
  output logic [CNT_WIDTH-1:0] cycle_cnt,
  output logic [CNT_WIDTH-1:0] stall_cnt,
  output logic [CNT_WIDTH-1:0] flush_cnt
);

  pipe_ctrl_state_t state, state_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= RUN;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    fetch_en     = 1'b0;
    fetch_flush  = 1'b0;
    if_id_en     = 1'b0;
    id_ex_en     = 1'b0;
    ex_mem_en    = 1'b0;
    mem_wb_en    = 1'b0;
    id_ex_bubble = 1'b0;
    case (state)
      RUN: begin
        if (mem_busy) begin
          // whole pipeline frozen; nothing else is evaluated
        end else if (decode_valid && ebreak_decoded) begin
          id_ex_en  = 1'b1;
          ex_mem_en = 1'b1;
          mem_wb_en = 1'b1;
          state_nxt = DRAIN;
        end else if (decode_valid && !decode_ready) begin
          id_ex_en     = 1'b1;
          id_ex_bubble = 1'b1;
          ex_mem_en    = 1'b1;
          mem_wb_en    = 1'b1;
        end else begin
          fetch_en    = 1'b1;
          if_id_en    = 1'b1;
          id_ex_en    = 1'b1;
          ex_mem_en   = 1'b1;
          mem_wb_en   = 1'b1;
          fetch_flush = decode_valid && jump;
        end
      end
      DRAIN: begin
        if (!mem_busy) begin
          id_ex_en     = 1'b1;
          id_ex_bubble = 1'b1;
          ex_mem_en    = 1'b1;
          mem_wb_en    = 1'b1;
        end
        if (ebreak_retired) state_nxt = HALTED;
      end
      HALTED: begin
        if (resume) state_nxt = RESTART;
      end
      RESTART: begin
        fetch_en    = 1'b1;
        fetch_flush = 1'b1;
        if_id_en    = 1'b1;
        id_ex_en    = 1'b1;
        ex_mem_en   = 1'b1;
        mem_wb_en   = 1'b1;
        state_nxt   = RUN;
      end
      default: state_nxt = RUN;
    endcase
  end

  assign halted = (state == HALTED);

`ifdef PIPELINE_PERF_COUNTERS_EN
  logic cycle_inc, stall_inc;

  // stalls counted are RUN freezes and RUN operand-hazard bubbles only
  assign cycle_inc = (state != HALTED);
  assign stall_inc = (state == RUN) &&
                     (mem_busy || (decode_valid && !ebreak_decoded && !decode_ready));

  perf_counters #(
    .CNT_WIDTH (CNT_WIDTH)
  ) u_perf_counters (
    .clk       (clk),
    .rst       (rst),
    .cycle_inc (cycle_inc),
    .stall_inc (stall_inc),
    .flush_inc (fetch_flush),
    .cycle_cnt (cycle_cnt),
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
  );
`else
  assign cycle_cnt = '0;
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipeline_controller.sv
// Directed bench for pipeline_controller: stall/flush/halt sequencing, async reset, counters.
module tb_pipeline_controller;

  localparam int CW = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic decode_valid = 1'b0, decode_ready = 1'b0, jump = 1'b0;
  logic ebreak_decoded = 1'b0, ebreak_retired = 1'b0, mem_busy = 1'b0, resume = 1'b0;
  logic fetch_en, fetch_flush, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, id_ex_bubble, halted;
  logic [CW-1:0] cycle_cnt, stall_cnt, flush_cnt;

  int n_chk  = 0;
  int n_pass = 0;

  // {fetch_en, fetch_flush, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, id_ex_bubble, halted}
  localparam logic [7:0] OUT_NORM   = 8'b1011_1100;
  localparam logic [7:0] OUT_JUMP   = 8'b1111_1100;
  localparam logic [7:0] OUT_STALL  = 8'b0001_1110;
  localparam logic [7:0] OUT_EBRK   = 8'b0001_1100;
  localparam logic [7:0] OUT_FROZEN = 8'b0000_0000;
  localparam logic [7:0] OUT_HALT   = 8'b0000_0001;

  // {decode_valid, decode_ready, jump, ebreak_decoded, ebreak_retired, mem_busy, resume}
  localparam logic [6:0] IN_NORM   = 7'b1100000;
  localparam logic [6:0] IN_HAZ    = 7'b1000000;
  localparam logic [6:0] IN_JMP    = 7'b1110000;
  localparam logic [6:0] IN_JMPHAZ = 7'b1010000;
  localparam logic [6:0] IN_EBRK   = 7'b1101000;
  localparam logic [6:0] IN_MBEBRK = 7'b1101010;
  localparam logic [6:0] IN_RES    = 7'b1100001;
  localparam logic [6:0] IN_MB     = 7'b1100010;
  localparam logic [6:0] IN_RET    = 7'b1100100;
  localparam logic [6:0] IN_NOISE  = 7'b1010010;
  localparam logic [6:0] IN_NOISER = 7'b1010011;

  logic [7:0] obs;
  assign obs = {fetch_en, fetch_flush, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, id_ex_bubble, halted};

  pipeline_controller #(.CNT_WIDTH(CW)) dut (
    .clk            (clk),
    .rst            (rst),
    .decode_valid   (decode_valid),
    .decode_ready   (decode_ready),
    .jump           (jump),
    .ebreak_decoded (ebreak_decoded),
    .ebreak_retired (ebreak_retired),
    .mem_busy       (mem_busy),
    .resume         (resume),
    .fetch_en       (fetch_en),
    .fetch_flush    (fetch_flush),
    .if_id_en       (if_id_en),
    .id_ex_en       (id_ex_en),
    .ex_mem_en      (ex_mem_en),
    .mem_wb_en      (mem_wb_en),
    .id_ex_bubble   (id_ex_bubble),
    .halted         (halted),
    .cycle_cnt      (cycle_cnt),
    .stall_cnt      (stall_cnt),
    .flush_cnt      (flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic drive(input logic [6:0] v);
    {decode_valid, decode_ready, jump, ebreak_decoded, ebreak_retired, mem_busy, resume} = v;
  endtask

  // called at a negedge: drive, check combinational outputs mid-cycle, advance one clock
  task automatic cyc(input string tag, input logic [6:0] v, input logic [7:0] exp);
    drive(v);
    #1;
    chk_val(tag, 32'(obs), 32'(exp));
    @(negedge clk);
  endtask

  task automatic chk_cnt(input string tag, input int c, input int s, input int f);
`ifdef PIPELINE_PERF_COUNTERS_EN
    chk_val({tag, ".cycle"}, cycle_cnt, c);
    chk_val({tag, ".stall"}, stall_cnt, s);
    chk_val({tag, ".flush"}, flush_cnt, f);
`else
    chk_val({tag, ".cycle"}, cycle_cnt, 0);
    chk_val({tag, ".stall"}, stall_cnt, 0);
    chk_val({tag, ".flush"}, flush_cnt, 0);
    if (c + s + f < 0) $display("negative count request in %s", tag);
`endif
  endtask

  initial begin
    drive(IN_NORM);
    #3;
    chk_val("rst_out", 32'(obs), 32'(OUT_NORM));
    chk_cnt("rst", 0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 5; i++) cyc("run_norm", IN_NORM, OUT_NORM);
    chk_cnt("after_norm", 5, 0, 0);

    cyc("hazard0", IN_HAZ, OUT_STALL);
    cyc("hazard1", IN_HAZ, OUT_STALL);
    chk_cnt("after_hazard", 7, 2, 0);

    cyc("jump", IN_JMP, OUT_JUMP);
    chk_cnt("after_jump", 8, 2, 1);
    cyc("jump_haz", IN_JMPHAZ, OUT_STALL);
    chk_cnt("after_jump_haz", 9, 3, 1);

    cyc("mb_ebrk", IN_MBEBRK, OUT_FROZEN);
    chk_cnt("after_mb_ebrk", 10, 4, 1);
    cyc("still_run", IN_NORM, OUT_NORM);

    cyc("ebrk", IN_EBRK, OUT_EBRK);
    cyc("drain0_res", IN_RES, OUT_STALL);
    cyc("drain1_mb", IN_MB, OUT_FROZEN);
    cyc("drain2_ret", IN_RET, OUT_STALL);
    chk_cnt("after_drain", 15, 4, 1);
    cyc("halt0", IN_NOISE, OUT_HALT);
    cyc("halt1", IN_NOISE, OUT_HALT);
    cyc("halt_res", IN_NOISER, OUT_HALT);
    chk_cnt("after_halt", 15, 4, 1);
    cyc("restart", IN_NORM, OUT_JUMP);
    cyc("run_again", IN_NORM, OUT_NORM);
    chk_cnt("after_restart", 17, 4, 2);

    cyc("ebrk2", IN_EBRK, OUT_EBRK);
    cyc("drain_b", IN_NORM, OUT_STALL);
    drive(IN_NORM);
    #2 rst = 1'b1;
    #1;
    chk_val("async_rst_out", 32'(obs), 32'(OUT_NORM));
    chk_cnt("async_rst", 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    cyc("post_rst", IN_NORM, OUT_NORM);
    chk_cnt("post_rst", 1, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
